// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data memory arbiter.
// Holds the FSM state encoding and default widths.
package dmem_arb_pkg;

  localparam int XLEN_D   = 64;
  localparam int LEN_W_D  = 6;
  localparam int STARVE_D = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_REQ  = 3'd1,
    S_RSP  = 3'd2,
    S_DONE = 3'd3,
    V_REQ  = 3'd4,
    V_RSP  = 3'd5
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one-outstanding req/gnt/rvalid memory bus.
// master drives req/we/addr/wdata; slave drives gnt/rvalid/rdata.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int XLEN = XLEN_D
);

  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_gnt;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );

endinterface

// File: rtl/dmem_vec_agu.sv
// dmem_vec_agu: strided burst address generator.
// Ports: load latches base/stride/len/we; step advances one element; busy while elements remain; last on the final element.
module dmem_vec_agu
  import dmem_arb_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             we_in,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  stride,
  input  logic [LEN_W-1:0] len,
  output logic [XLEN-1:0]  addr,
  output logic             we,
  output logic             busy,
  output logic             last
);

  logic [XLEN-1:0]  stride_q;
  logic [LEN_W-1:0] rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      stride_q <= '0;
      rem      <= '0;
      we       <= 1'b0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
      rem      <= len;
      we       <= we_in;
    end else if (step) begin
      addr <= addr + stride_q;
      rem  <= rem - LEN_W'(1);
    end
  end

  // zero remaining means no burst: a len==0 burst never looks busy
  assign busy = |rem;
  assign last = (rem == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between scalar MEM stage and vector LSU.
// Ports: clk/rst; scalar s_*; vector v_*; memory bus mem (master).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN       = XLEN_D,
  parameter int LEN_W      = LEN_W_D,
  parameter int STARVE_LIM = STARVE_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_rd,
  input  logic             s_wr,
  input  logic [XLEN-1:0]  s_addr,
  input  logic [XLEN-1:0]  s_wdata,
  output logic [XLEN-1:0]  s_rdata,
  output logic             s_stall,
  input  logic             v_req,
  output logic             v_ack,
  input  logic             v_we,
  input  logic [XLEN-1:0]  v_base,
  input  logic [XLEN-1:0]  v_stride,
  input  logic [LEN_W-1:0] v_len,
  input  logic [XLEN-1:0]  v_wdata,
  output logic             v_wpop,
  output logic [XLEN-1:0]  v_rdata,
  output logic             v_rvalid,
  output logic             v_busy,
  output logic             v_done,
  dmem_arbiter_if.master   mem
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  state_t          state, nxt;
  logic [SW-1:0]   streak;
  logic            s_pend, v_pend;
  logic            acc, step, cap;
  logic            st_inc, st_clr;
  logic            agu_we, agu_last;
  logic [XLEN-1:0] agu_addr;
  logic            m_req, m_we;
  logic [XLEN-1:0] m_addr, m_wdata;

  dmem_vec_agu #(
    .XLEN  (XLEN),
    .LEN_W (LEN_W)
  ) u_agu (
    .clk    (clk),
    .rst    (rst),
    .load   (acc),
    .step   (step),
    .we_in  (v_we),
    .base   (v_base),
    .stride (v_stride),
    .len    (v_len),
    .addr   (agu_addr),
    .we     (agu_we),
    .busy   (v_busy),
    .last   (agu_last)
  );

  assign s_pend  = s_rd | s_wr;
  assign v_pend  = v_busy | v_req;
  assign s_stall = s_pend & (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      streak  <= '0;
      s_rdata <= '0;
      v_done  <= 1'b0;
    end else begin
      state  <= nxt;
      v_done <= (step & agu_last) |
                (acc & (v_len == '0));
      if (st_clr) streak <= '0;
      else if (st_inc) streak <= streak + SW'(1);
      if (cap) s_rdata <= mem.m_rdata;
    end
  end

  always_comb begin
    nxt      = state;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    v_ack    = 1'b0;
    v_wpop   = 1'b0;
    v_rvalid = 1'b0;
    acc      = 1'b0;
    step     = 1'b0;
    cap      = 1'b0;
    st_inc   = 1'b0;
    st_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_pend &&
            (!v_pend || streak < SW'(STARVE_LIM))) begin
          nxt    = S_REQ;
          st_inc = v_pend;
        end else if (v_busy) begin
          nxt    = V_REQ;
          st_clr = 1'b1;
        end else if (v_req && !v_done) begin
          // blocked in the v_done cycle so bursts never overlap
          acc   = 1'b1;
          v_ack = 1'b1;
        end
      end
      S_REQ: begin
        m_req   = 1'b1;
        m_addr  = s_addr;
        m_we    = s_wr;
        m_wdata = s_wdata;
        if (mem.m_gnt) nxt = s_wr ? S_DONE : S_RSP;
      end
      S_RSP: begin
        if (mem.m_rvalid) begin
          cap = 1'b1;
          nxt = S_DONE;
        end
      end
      S_DONE: nxt = IDLE;
      V_REQ: begin
        m_req   = 1'b1;
        m_addr  = agu_addr;
        m_we    = agu_we;
        m_wdata = v_wdata;
        if (mem.m_gnt) begin
          if (agu_we) begin
            v_wpop = 1'b1;
            step   = 1'b1;
            nxt    = IDLE;
          end else begin
            nxt = V_RSP;
          end
        end
      end
      V_RSP: begin
        if (mem.m_rvalid) begin
          v_rvalid = 1'b1;
          step     = 1'b1;
          nxt      = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign v_rdata     = v_rvalid ? mem.m_rdata : '0;
  assign mem.m_req   = m_req;
  assign mem.m_we    = m_we;
  assign mem.m_addr  = m_addr;
  assign mem.m_wdata = m_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Memory responder grants immediately and returns read data after rv_dly cycles.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_rd, s_wr;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic        s_stall;
  logic        v_req, v_ack, v_we;
  logic [63:0] v_base, v_stride, v_wdata, v_rdata;
  logic [5:0]  v_len;
  logic        v_wpop, v_rvalid, v_busy, v_done;

  int          rv_dly;
  logic        rd_fix_en;
  logic [63:0] rd_fix;
  logic [63:0] addr_l;
  int          cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.XLEN(64)) mem ();

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .s_rd     (s_rd),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_stall  (s_stall),
    .v_req    (v_req),
    .v_ack    (v_ack),
    .v_we     (v_we),
    .v_base   (v_base),
    .v_stride (v_stride),
    .v_len    (v_len),
    .v_wdata  (v_wdata),
    .v_wpop   (v_wpop),
    .v_rdata  (v_rdata),
    .v_rvalid (v_rvalid),
    .v_busy   (v_busy),
    .v_done   (v_done),
    .mem      (mem)
  );

  assign mem.m_gnt    = mem.m_req;
  assign mem.m_rvalid = (cnt == 1);
  assign mem.m_rdata  = mem.m_rvalid ?
                        (rd_fix_en ? rd_fix : addr_l) : 64'd0;

  always @(posedge clk) begin
    if (rst) begin
      cnt    <= 0;
      addr_l <= 64'd0;
    end else if (mem.m_req && mem.m_gnt && !mem.m_we) begin
      cnt    <= rv_dly;
      addr_l <= mem.m_addr;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] vl_exp [3];
  int   nreq, drop, ng, nrv, last_rv, done_c;
  int   gi, vk, sc, wpop_n, vdone_n, nbad;
  logic ack_now, pop_now, sdone_now, isv;

  initial begin
    vl_exp[0] = 64'h1000;
    vl_exp[1] = 64'hFF8;
    vl_exp[2] = 64'hFF0;
    rst = 1'b1;
    s_rd = 1'b0; s_wr = 1'b0;
    s_addr = 64'd0; s_wdata = 64'd0;
    v_req = 1'b0; v_we = 1'b0;
    v_base = 64'd0; v_stride = 64'd0;
    v_len = 6'd0; v_wdata = 64'd0;
    rv_dly = 1; rd_fix_en = 1'b0; rd_fix = 64'd0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_stall", 64'(s_stall), 64'd0);
    chk("rst_mreq", 64'(mem.m_req), 64'd0);
    chk("rst_busy", 64'(v_busy), 64'd0);
    chk("rst_done", 64'(v_done), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    tick();

    // scalar store, gnt immediate
    s_wr = 1'b1; s_addr = 64'h100; s_wdata = 64'hDEAD;
    @(negedge clk);
    chk("st_c0_stall", 64'(s_stall), 64'd1);
    chk("st_c0_mreq", 64'(mem.m_req), 64'd0);
    tick();
    @(negedge clk);
    chk("st_c1_mreq", 64'(mem.m_req), 64'd1);
    chk("st_c1_we", 64'(mem.m_we), 64'd1);
    chk("st_c1_addr", mem.m_addr, 64'h100);
    chk("st_c1_wdata", mem.m_wdata, 64'hDEAD);
    chk("st_c1_stall", 64'(s_stall), 64'd1);
    tick();
    @(negedge clk);
    chk("st_c2_stall", 64'(s_stall), 64'd0);
    chk("st_c2_mreq", 64'(mem.m_req), 64'd0);
    tick();
    s_wr = 1'b0;

    // scalar load, rvalid 3 cycles after gnt
    rv_dly = 3; rd_fix_en = 1'b1; rd_fix = 64'h1234;
    s_rd = 1'b1; s_addr = 64'h200;
    nreq = 0; drop = -1;
    for (int c = 0; c < 20 && drop < 0; c++) begin
      @(negedge clk);
      if (mem.m_req) nreq++;
      if (!s_stall) begin
        drop = c;
        chk("ld_rdata", s_rdata, 64'h1234);
      end
      tick();
    end
    s_rd = 1'b0; rd_fix_en = 1'b0;
    chk("ld_stall_end", 64'(drop), 64'd5);
    chk("ld_nreq", 64'(nreq), 64'd1);

    // vector load, negative stride
    rv_dly = 1; v_we = 1'b0;
    v_base = 64'h1000; v_stride = -64'd8; v_len = 6'd3;
    v_req = 1'b1;
    @(negedge clk);
    chk("vl_ack", 64'(v_ack), 64'd1);
    tick();
    v_req = 1'b0;
    chk("vl_busy", 64'(v_busy), 64'd1);
    ng = 0; nrv = 0; last_rv = -100; done_c = -1;
    for (int c = 1; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (mem.m_req && mem.m_gnt) begin
        if (ng < 3)
          chk($sformatf("vl_addr%0d", ng), mem.m_addr, vl_exp[ng]);
        ng++;
      end
      if (v_rvalid) begin
        if (nrv < 3)
          chk($sformatf("vl_rdata%0d", nrv), v_rdata, vl_exp[nrv]);
        nrv++;
        last_rv = c;
      end
      if (v_done) done_c = c;
      tick();
    end
    chk("vl_ngrant", 64'(ng), 64'd3);
    chk("vl_nrvalid", 64'(nrv), 64'd3);
    chk("vl_done_lat", 64'(done_c - last_rv), 64'd1);
    chk("vl_busy_end", 64'(v_busy), 64'd0);

    // starvation guard: scalar stores vs vector store len 8
    v_we = 1'b1; v_base = 64'h2000; v_stride = 64'd8;
    v_len = 6'd8; v_wdata = 64'hA0; v_req = 1'b1;
    s_wr = 1'b1; s_addr = 64'h300; s_wdata = 64'h55;
    gi = 0; vk = 0; sc = 0; wpop_n = 0; vdone_n = 0;
    for (int c = 0; c < 400 && vdone_n == 0; c++) begin
      @(negedge clk);
      ack_now = v_ack;
      pop_now = v_wpop;
      sdone_now = s_wr && !s_stall;
      if (mem.m_req && mem.m_gnt) begin
        isv = (mem.m_addr >= 64'h2000);
        if (gi < 40)
          chk($sformatf("sv_kind%0d", gi), 64'(isv),
              64'(gi % 5 == 4));
        if (isv) begin
          chk($sformatf("sv_vaddr%0d", vk), mem.m_addr,
              64'h2000 + 64'(8 * vk));
          chk($sformatf("sv_vdata%0d", vk), mem.m_wdata,
              64'hA0 + 64'(vk));
          vk++;
        end else begin
          chk($sformatf("sv_swe%0d", gi), 64'(mem.m_we), 64'd1);
        end
        gi++;
      end
      if (v_done) vdone_n++;
      tick();
      if (ack_now) v_req = 1'b0;
      if (pop_now) begin
        wpop_n++;
        v_wdata = 64'hA0 + 64'(wpop_n);
      end
      if (sdone_now) begin
        sc++;
        if (sc == 32) s_wr = 1'b0;
        else s_addr = 64'h300 + 64'(8 * sc);
      end
    end
    chk("sv_wpops", 64'(wpop_n), 64'd8);
    chk("sv_vgrants", 64'(vk), 64'd8);
    chk("sv_grants", 64'(gi), 64'd40);
    chk("sv_done", 64'(vdone_n), 64'd1);
    chk("sv_scalar", 64'(sc), 64'd32);

    // zero-length burst
    v_we = 1'b0; v_len = 6'd0; v_base = 64'h3000; v_req = 1'b1;
    @(negedge clk);
    chk("zl_ack", 64'(v_ack), 64'd1);
    chk("zl_mreq0", 64'(mem.m_req), 64'd0);
    tick();
    @(negedge clk);
    chk("zl_done", 64'(v_done), 64'd1);
    chk("zl_busy", 64'(v_busy), 64'd0);
    chk("zl_noack", 64'(v_ack), 64'd0);
    chk("zl_mreq1", 64'(mem.m_req), 64'd0);
    tick();
    v_req = 1'b0;
    @(negedge clk);
    chk("zl_done_end", 64'(v_done), 64'd0);
    chk("zl_mreq2", 64'(mem.m_req), 64'd0);
    tick();

    // reset while waiting in V_RSP
    v_we = 1'b0; v_base = 64'h4000; v_stride = 64'd16;
    v_len = 6'd4; rv_dly = 3; v_req = 1'b1;
    @(negedge clk);
    chk("rs_ack", 64'(v_ack), 64'd1);
    tick();
    v_req = 1'b0;
    ng = 0;
    for (int c = 0; c < 20 && ng == 0; c++) begin
      @(negedge clk);
      if (mem.m_req && mem.m_gnt) ng = 1;
      tick();
    end
    chk("rs_granted", 64'(ng), 64'd1);
    chk("rs_busy_pre", 64'(v_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_mreq", 64'(mem.m_req), 64'd0);
    chk("rs_maddr", mem.m_addr, 64'd0);
    chk("rs_busy", 64'(v_busy), 64'd0);
    chk("rs_done", 64'(v_done), 64'd0);
    chk("rs_rvalid", 64'(v_rvalid), 64'd0);
    chk("rs_ack0", 64'(v_ack), 64'd0);
    chk("rs_stall", 64'(s_stall), 64'd0);
    chk("rs_rdata", s_rdata, 64'd0);
    nbad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (v_done || mem.m_req || v_rvalid) nbad++;
    end
    chk("rs_quiet", 64'(nbad), 64'd0);
    tick();

    // fresh burst after reset starts at new base
    v_base = 64'h5000; v_stride = 64'd8; v_len = 6'd2;
    rv_dly = 1; v_req = 1'b1;
    @(negedge clk);
    chk("rb_ack", 64'(v_ack), 64'd1);
    tick();
    v_req = 1'b0;
    ng = 0; done_c = -1;
    for (int c = 0; c < 30 && done_c < 0; c++) begin
      @(negedge clk);
      if (mem.m_req && mem.m_gnt) begin
        if (ng < 2)
          chk($sformatf("rb_addr%0d", ng), mem.m_addr,
              64'h5000 + 64'(8 * ng));
        ng++;
      end
      if (v_done) done_c = c;
      tick();
    end
    chk("rb_ngrant", 64'(ng), 64'd2);
    chk("rb_done", 64'(done_c >= 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
